// File: rtl/otp_ctrl_ecc_scrub_pkg.sv
// Shared types and constants for the OTP buffer ECC scrubber.
// Holds the sparse FSM encoding and the inverted SECDED 72/64 column table.
package otp_ctrl_ecc_scrub_pkg;

    localparam int ScrubCntWidth = 8;

    // Check bits of the all-zero data word; the code is inverted so erased storage is not valid.
    localparam logic [7:0] SecdedInv7264ZeroEcc = 8'hAA;

    // Pairwise Hamming distance >= 3, so a single upset never lands on another legal state.
    typedef enum logic [5:0] {
        ScrubIdle  = 6'b000111,
        ScrubRead  = 6'b011001,
        ScrubCheck = 6'b101010,
        ScrubWrite = 6'b110100,
        ScrubError = 6'b111111
    } scrub_state_e;

    // Hsiao-style column for data bit idx: all 56 weight-3 codes, then the first 8 weight-5 codes.
    function automatic logic [7:0] secded_col(input int unsigned idx);
        int unsigned n;
        logic [7:0]  col;
        n   = 0;
        col = '0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int v = 1; v < 256; v++) begin
                if ($countones(v[7:0]) == w) begin
                    if (n == idx) col = v[7:0];
                    n++;
                end
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/otp_ctrl_ecc_scrub_secded.sv
// Inverted SECDED 72/64 decoder: corrects single-bit errors, flags double-bit errors.
// err_o: 2'b00 clean, 2'b01 corrected, 2'b10 uncorrectable.
module otp_ctrl_ecc_scrub_secded
    import otp_ctrl_ecc_scrub_pkg::*;
(
    input  logic [71:0] data_i,
    output logic [63:0] data_o,
    output logic [1:0]  err_o
);

    logic [63:0][7:0] contrib;
    logic [63:0]      flip;
    logic [7:0]       syndrome;

    for (genvar i = 0; i < 64; i++) begin : g_col
        localparam logic [7:0] Col = secded_col(i);
        assign contrib[i] = data_i[i] ? Col : 8'h00;
        assign flip[i]    = (syndrome == Col);
    end

    always_comb begin
        syndrome = data_i[71:64] ^ SecdedInv7264ZeroEcc;
        for (int i = 0; i < 64; i++) begin
            syndrome = syndrome ^ contrib[i];
        end
    end

    assign data_o = data_i[63:0] ^ flip;

    // Data columns all have odd weight, so an odd syndrome means exactly one flipped bit.
    always_comb begin
        err_o = 2'b00;
        if (syndrome != 8'h00) begin
            err_o = (^syndrome) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/otp_ctrl_ecc_scrub.sv
// Background scrubber for an ECC-protected OTP partition buffer: reads every word,
// writes back corrected data on single-bit errors and locks up on double-bit errors.
//   state  | meaning
//   Idle   | waiting for start_i
//   Read   | issuing (or, while paused, holding) the read of addr
//   Check  | decoding the codeword returned for addr
//   Write  | issuing (or, while paused, holding) the corrected write-back
//   Error  | uncorrectable error seen; terminal until reset
module otp_ctrl_ecc_scrub
    import otp_ctrl_ecc_scrub_pkg::*;
#(
    parameter  int Depth    = 128,
    parameter  int CntWidth = ScrubCntWidth,
    localparam int Aw       = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                pause_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_req_o,
    output logic [Aw-1:0]       mem_addr_o,
    input  logic [71:0]         mem_rdata_i,
    output logic                mem_wren_o,
    output logic [63:0]         mem_wdata_o,
    output logic [CntWidth-1:0] corr_cnt_o,
    output logic                fatal_err_o
);

    localparam logic [Aw-1:0]       LastAddr = Aw'(Depth - 1);
    localparam logic [CntWidth-1:0] CntMax   = '1;

    scrub_state_e        state_q, state_d;
    logic [Aw-1:0]       addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                req_q, req_d;
    logic                wren_q, wren_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                fatal_q, fatal_d;
    logic                word_done;
    logic [63:0]         dec_data;
    logic [1:0]          dec_err;

    otp_ctrl_ecc_scrub_secded u_dec (
        .data_i (mem_rdata_i),
        .data_o (dec_data),
        .err_o  (dec_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ScrubIdle;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            fatal_q <= fatal_d;
        end
    end

    // A strobe flop being high means the access is issued this cycle, so leave the state.
    always_comb begin : p_next
        state_d   = state_q;
        addr_d    = addr_q;
        word_done = 1'b0;
        case (state_q)
            ScrubIdle: begin
                if (start_i) begin
                    state_d = ScrubRead;
                    addr_d  = '0;
                end
            end
            ScrubRead: begin
                if (req_q) state_d = ScrubCheck;
            end
            ScrubCheck: begin
                case (dec_err)
                    2'b00:   word_done = 1'b1;
                    2'b01:   state_d   = ScrubWrite;
                    default: state_d   = ScrubError;
                endcase
            end
            ScrubWrite: begin
                if (wren_q) word_done = 1'b1;
            end
            ScrubError: state_d = ScrubError;
            default:    state_d = ScrubError;
        endcase
        if (word_done) begin
            if (addr_q == LastAddr) begin
                state_d = ScrubIdle;
                addr_d  = '0;
            end else begin
                state_d = ScrubRead;
                addr_d  = addr_q + Aw'(1);
            end
        end
    end

    always_comb begin : p_out
        req_d   = (state_d == ScrubRead) && !pause_i;
        wren_d  = (state_d == ScrubWrite) && !pause_i;
        busy_d  = (state_d == ScrubRead) || (state_d == ScrubCheck) || (state_d == ScrubWrite);
        done_d  = word_done && (addr_q == LastAddr);
        fatal_d = fatal_q || (state_d == ScrubError);
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if ((state_q == ScrubCheck) && (dec_err == 2'b01)) begin
            wdata_d = dec_data;
            if (cnt_q != CntMax) cnt_d = cnt_q + CntWidth'(1);
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wren_o  = wren_q;
    assign mem_wdata_o = wdata_q;
    assign corr_cnt_o  = cnt_q;
    assign fatal_err_o = fatal_q;

endmodule

// File: tb/tb_otp_ctrl_ecc_scrub.sv
// Scoreboard bench for otp_ctrl_ecc_scrub: stimulus pushes expected reads, writes and
// done cycles; a negedge monitor pops and compares whenever the DUT strobes.
module tb_otp_ctrl_ecc_scrub;
    import otp_ctrl_ecc_scrub_pkg::*;

    localparam logic [71:0] Zcw = {SecdedInv7264ZeroEcc, 64'h0};

    typedef struct {
        int          addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    // Depth=4, CntWidth=2 instance
    logic        start, pause, busy, done, req, wren, fatal;
    logic [1:0]  addr, cnt;
    logic [63:0] wdata;
    logic [71:0] rdata;
    logic [71:0] mem [4];

    // Depth=1 instance
    logic        start1, busy1, done1, req1, wren1, fatal1;
    logic [0:0]  addr1;
    logic [7:0]  cnt1;
    logic [63:0] wdata1;
    logic [71:0] rdata1;
    logic [71:0] mem1;

    int  exp_rd[$];
    wr_t exp_wr[$];
    int  exp_done[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (req)  rdata  <= mem[addr];
        if (req1) rdata1 <= mem1;
    end

    otp_ctrl_ecc_scrub #(.Depth(4), .CntWidth(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause),
        .busy_o(busy), .done_o(done), .mem_req_o(req), .mem_addr_o(addr),
        .mem_rdata_i(rdata), .mem_wren_o(wren), .mem_wdata_o(wdata),
        .corr_cnt_o(cnt), .fatal_err_o(fatal)
    );

    otp_ctrl_ecc_scrub #(.Depth(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .pause_i(1'b0),
        .busy_o(busy1), .done_o(done1), .mem_req_o(req1), .mem_addr_o(addr1),
        .mem_rdata_i(rdata1), .mem_wren_o(wren1), .mem_wdata_o(wdata1),
        .corr_cnt_o(cnt1), .fatal_err_o(fatal1)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name, input int val);
        vectors++;
        miscompares++;
        $display("FAIL %s: strobe seen with value %0h, none expected (cycle %0d)", name, val, cyc);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (req && wren) chk("req_wren_exclusive", 64'(req & wren), 64'd0);
        if (req) begin
            if (exp_rd.size() == 0) unexpected("read", int'(addr));
            else chk("read_addr", 64'(addr), 64'(exp_rd.pop_front()));
        end
        if (wren) begin
            if (exp_wr.size() == 0) unexpected("write", int'(addr));
            else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("write_addr", 64'(addr), 64'(e.addr));
                chk("write_data", wdata, e.data);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) unexpected("done", cyc);
            else chk("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
        end
    end

    task automatic push_reads(input int n);
        for (int i = 0; i < n; i++) exp_rd.push_back(i);
    endtask

    task automatic push_write(input int a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: done_o not seen within %0d cycles", name, bound);
        end
        @(negedge clk);
    endtask

    task automatic fill_clean();
        for (int i = 0; i < 4; i++) mem[i] = Zcw;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'(busy),  64'd0);
        chk({tag, "_done"},  64'(done),  64'd0);
        chk({tag, "_req"},   64'(req),   64'd0);
        chk({tag, "_addr"},  64'(addr),  64'd0);
        chk({tag, "_wren"},  64'(wren),  64'd0);
        chk({tag, "_wdata"}, wdata,      64'd0);
        chk({tag, "_cnt"},   64'(cnt),   64'd0);
        chk({tag, "_fatal"}, 64'(fatal), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int hits;
        start  = 1'b0;
        pause  = 1'b0;
        start1 = 1'b0;
        fill_clean();
        mem1 = Zcw;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All clean: 4 reads, done 8 cycles after the start edge
        s = cyc;
        push_reads(4);
        exp_done.push_back(s + 1 + 8);
        pulse_start();
        chk("clean_busy", 64'(busy), 64'd1);
        wait_done("clean", 40);
        chk("clean_cnt", 64'(cnt), 64'd0);
        chk("clean_busy_end", 64'(busy), 64'd0);

        // Data bit 5 of word 2 flipped
        mem[2] = Zcw ^ (72'h1 << 5);
        s = cyc;
        push_reads(4);
        push_write(2, 64'h0);
        exp_done.push_back(s + 1 + 9);
        pulse_start();
        wait_done("single", 40);
        chk("single_cnt", 64'(cnt), 64'd1);

        // Pause held across 5 sampling edges while word 3 is pending
        fill_clean();
        s = cyc;
        push_reads(4);
        exp_done.push_back(s + 1 + 8 + 5);
        pulse_start();
        while (cyc < s + 6) @(negedge clk);
        pause = 1'b1;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req) hits++;
        end
        pause = 1'b0;
        chk("pause_no_req", 64'(hits), 64'd0);
        wait_done("pause", 40);

        // Three corrections (data bit 0, check bit 3, data bit 63): counter saturates at 3
        mem[0] = Zcw ^ (72'h1 << 0);
        mem[1] = Zcw ^ (72'h1 << 67);
        mem[3] = Zcw ^ (72'h1 << 63);
        s = cyc;
        push_reads(4);
        push_write(0, 64'h0);
        push_write(1, 64'h0);
        push_write(3, 64'h0);
        exp_done.push_back(s + 1 + 11);
        pulse_start();
        wait_done("multi", 60);
        chk("sat_cnt", 64'(cnt), 64'd3);

        fill_clean();
        mem[2] = Zcw ^ (72'h1 << 40);
        s = cyc;
        push_reads(4);
        push_write(2, 64'h0);
        exp_done.push_back(s + 1 + 9);
        pulse_start();
        wait_done("sat_hold", 40);
        chk("sat_cnt_hold", 64'(cnt), 64'd3);

        // Reset asserted while the write-back of word 1 is on the bus
        fill_clean();
        mem[1] = Zcw ^ (72'h1 << 17);
        s = cyc;
        push_reads(2);
        push_write(1, 64'h0);
        pulse_start();
        while (cyc < s + 5) @(negedge clk);
        chk("rstw_wren_before", 64'(wren), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("rstw");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wren) hits++;
        end
        chk("rstw_no_write", 64'(hits), 64'd0);

        // Double-bit error in word 1
        fill_clean();
        mem[1] = Zcw ^ (72'h1 << 7) ^ (72'h1 << 20);
        s = cyc;
        push_reads(2);
        pulse_start();
        while (cyc < s + 4) @(negedge clk);
        chk("dbl_fatal_in_check", 64'(fatal), 64'd0);
        @(negedge clk);
        chk("dbl_fatal", 64'(fatal), 64'd1);
        chk("dbl_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (10) @(negedge clk);
        chk("dbl_fatal_sticky", 64'(fatal), 64'd1);
        chk("dbl_start_ignored", 64'(busy), 64'd0);
        rst_n = 1'b0;
        #1 chk("dbl_fatal_cleared", 64'(fatal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Depth=1: one read at address 0 and the first Next ends the sweep
        s = cyc;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("d1_req", 64'(req1), 64'd1);
        chk("d1_addr", 64'(addr1), 64'd0);
        @(negedge clk);
        chk("d1_done_early", 64'(done1), 64'd0);
        @(negedge clk);
        chk("d1_done", 64'(done1), 64'd1);
        chk("d1_busy", 64'(busy1), 64'd0);
        chk("d1_addr_end", 64'(addr1), 64'd0);
        @(negedge clk);

        chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
